// File: rtl/buffer_pkg.sv
// Shared definitions for the output circular buffer.
//   - Default geometry (word width, slot count, words per write group).
//   - Default pointer / count widths derived from that geometry.
//   - wrap_add: pointer addition modulo the slot count.
package buffer_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int DEPTH_DEF     = 8;
  localparam int PAR_WRITE_DEF = 2;

  localparam int PTR_W = $clog2(DEPTH_DEF);
  localparam int CNT_W = $clog2(DEPTH_DEF + 1);

  // Wrapped pointer add. With a power-of-two depth the modulo reduces to
  // dropping the carry out of the pointer width.
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned depth);
    return (ptr + inc) % depth;
  endfunction

endpackage

// File: rtl/buffer_regfile.sv
// Word storage for the output circular buffer.
//   clk      : rising-edge clock
//   we       : write a full group this cycle
//   wr_base  : slot of word 0; word k goes to (wr_base + k) mod DEPTH
//   wr_data  : PAR_WRITE words, word k at wr_data[k*DATA_W +: DATA_W]
//   rd_addr  : read slot
//   rd_data  : mem[rd_addr]; captured by the output register in the top level
module buffer_regfile
  import buffer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int PAR_WRITE = PAR_WRITE_DEF
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(DEPTH)-1:0]      wr_base,
  input  logic [PAR_WRITE*DATA_W-1:0]   wr_data,
  input  logic [$clog2(DEPTH)-1:0]      rd_addr,
  output logic [DATA_W-1:0]             rd_data
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; pointers and count alone decide
  // which slots hold live data, so a reset here would only cost area.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < PAR_WRITE; k++) begin
        mem[PW'(wrap_add(32'(wr_base), 32'(k), 32'(DEPTH)))] <= wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/output_circular_buffer.sv
// Circular word buffer downstream of the write-buffer controller.
//   clk, rst        : clock; synchronous active-high reset
//   inner_rst       : synchronous soft clear, same effect as rst
//   write_req       : controller wants a slot; qualifies ready
//   write_in_buffer : one-cycle write strobe carrying PAR_WRITE words on din
//   ready           : room for a whole group (combinational, pre-edge count)
//   read_en         : consumer pops one word
//   dout/dout_valid : registered read data, valid pulse one cycle after read_en
//   empty/full/count: occupancy
//   overflow_err    : sticky, strobe arrived without room
//   underflow_err   : sticky, read_en while empty
module output_circular_buffer
  import buffer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int PAR_WRITE = PAR_WRITE_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          inner_rst,
  input  logic                          write_req,
  input  logic                          write_in_buffer,
  input  logic [PAR_WRITE*DATA_W-1:0]   din,
  output logic                          ready,
  input  logic                          read_en,
  output logic [DATA_W-1:0]             dout,
  output logic                          dout_valid,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          overflow_err,
  output logic                          underflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     room;
  logic              room_ok;
  logic              wr_accept;
  logic              rd_accept;
  logic              clear;
  logic [DATA_W-1:0] rd_word;

  assign clear     = rst | inner_rst;
  assign room      = CW'(DEPTH) - count;
  assign room_ok   = room >= CW'(PAR_WRITE);
  assign wr_accept = write_in_buffer & room_ok;
  assign rd_accept = read_en & (count != '0);

  assign ready = write_req & room_ok;
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // With count != 0 and room for a group, the write slots never overlap the
  // head, so a same-cycle read always sees the old head word.
  buffer_regfile #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .PAR_WRITE (PAR_WRITE)
  ) u_regfile (
    .clk     (clk),
    .we      (wr_accept),
    .wr_base (wr_ptr),
    .wr_data (din),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      dout          <= '0;
      dout_valid    <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= PW'(wrap_add(32'(wr_ptr), 32'(PAR_WRITE), 32'(DEPTH)));
      end
      if (rd_accept) begin
        rd_ptr <= PW'(wrap_add(32'(rd_ptr), 32'd1, 32'(DEPTH)));
        dout   <= rd_word;
      end
      count <= count + (wr_accept ? CW'(PAR_WRITE) : CW'(0))
                     - (rd_accept ? CW'(1) : CW'(0));
      dout_valid <= rd_accept;
      if (write_in_buffer && !room_ok) overflow_err <= 1'b1;
      if (read_en && (count == '0))    underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_circular_buffer.sv
// Self-checking bench for output_circular_buffer (DATA_W=8, DEPTH=8, PAR_WRITE=2).
// A queue-based model tracks contents and flags; a negedge process compares
// every output against it, and directed sequences add literal expectations.
module tb_output_circular_buffer;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 8;
  localparam int PAR_WRITE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inner_rst = 1'b0;
  logic        write_req = 1'b0;
  logic        write_in_buffer = 1'b0;
  logic [15:0] din = '0;
  logic        ready;
  logic        read_en = 1'b0;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        overflow_err;
  logic        underflow_err;

  output_circular_buffer #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .PAR_WRITE (PAR_WRITE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .inner_rst       (inner_rst),
    .write_req       (write_req),
    .write_in_buffer (write_in_buffer),
    .din             (din),
    .ready           (ready),
    .read_en         (read_en),
    .dout            (dout),
    .dout_valid      (dout_valid),
    .empty           (empty),
    .full            (full),
    .count           (count),
    .overflow_err    (overflow_err),
    .underflow_err   (underflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_ovf;
  logic       m_unf;
  logic       started = 1'b0;

  always @(posedge clk) begin
    if (rst || inner_rst) begin
      mq.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      automatic bit had_room = (DEPTH - mq.size()) >= PAR_WRITE;
      automatic bit had_data = mq.size() != 0;
      m_valid = 1'b0;
      if (read_en) begin
        if (had_data) begin
          m_dout  = mq.pop_front();
          m_valid = 1'b1;
        end else begin
          m_unf = 1'b1;
        end
      end
      if (write_in_buffer) begin
        if (had_room) begin
          mq.push_back(din[7:0]);
          mq.push_back(din[15:8]);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      automatic int sz = mq.size();
      check("cmp_count", 32'(count), 32'(sz));
      check("cmp_empty", 32'(empty), 32'(sz == 0));
      check("cmp_full", 32'(full), 32'(sz == DEPTH));
      check("cmp_ready", 32'(ready), 32'(write_req && ((DEPTH - sz) >= PAR_WRITE)));
      check("cmp_dout_valid", 32'(dout_valid), 32'(m_valid));
      check("cmp_dout", 32'(dout), 32'(m_dout));
      check("cmp_overflow", 32'(overflow_err), 32'(m_ovf));
      check("cmp_underflow", 32'(underflow_err), 32'(m_unf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_grp(input logic [7:0] w0, input logic [7:0] w1);
    write_req       = 1'b1;
    write_in_buffer = 1'b1;
    din             = {w1, w0};
    tick();
    write_in_buffer = 1'b0;
  endtask

  task automatic pop(input logic [7:0] exp, input string name);
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check(name, 32'(dout), 32'(exp));
    check({name, "_valid"}, 32'(dout_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] seq [8];
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    // 1. reset state
    tick();
    tick();
    rst = 1'b0;
    started = 1'b1;
    write_req = 1'b1;
    #1;
    check("t1_ready", 32'(ready), 32'd1);
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_count", 32'(count), 32'd0);
    check("t1_flags", 32'({overflow_err, underflow_err, dout_valid}), 32'd0);

    // 2. fill to full, then overflow
    write_grp(8'h11, 8'h22);
    write_grp(8'h33, 8'h44);
    write_grp(8'h55, 8'h66);
    write_grp(8'h77, 8'h88);
    check("t2_full", 32'(full), 32'd1);
    check("t2_ready", 32'(ready), 32'd0);
    check("t2_count", 32'(count), 32'd8);
    write_grp(8'hEE, 8'hFF);
    check("t2_ovf", 32'(overflow_err), 32'd1);
    check("t2_count_hold", 32'(count), 32'd8);

    // 3. drain, then underflow
    for (int i = 0; i < 8; i++) pop(seq[i], $sformatf("t3_pop%0d", i));
    check("t3_empty", 32'(empty), 32'd1);
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check("t3_unf", 32'(underflow_err), 32'd1);
    check("t3_dout_hold", 32'(dout), 32'h88);
    check("t3_valid_low", 32'(dout_valid), 32'd0);

    // 4. wrap across the end of storage
    do_reset();
    write_grp(8'h01, 8'h02);
    write_grp(8'h03, 8'h04);
    write_grp(8'h05, 8'h06);
    for (int i = 0; i < 6; i++) pop(8'(i + 1), $sformatf("t4_pre%0d", i));
    write_grp(8'hA1, 8'hA2);
    write_grp(8'hB1, 8'hB2);
    check("t4_count", 32'(count), 32'd4);
    pop(8'hA1, "t4_a1");
    pop(8'hA2, "t4_a2");
    pop(8'hB1, "t4_b1");
    pop(8'hB2, "t4_b2");

    // 5. simultaneous write and read at count 6
    do_reset();
    write_grp(8'h01, 8'h02);
    write_grp(8'h03, 8'h04);
    write_grp(8'h05, 8'h06);
    write_in_buffer = 1'b1;
    din = {8'h08, 8'h07};
    read_en = 1'b1;
    tick();
    write_in_buffer = 1'b0;
    read_en = 1'b0;
    check("t5_count", 32'(count), 32'd7);
    check("t5_ready", 32'(ready), 32'd0);
    check("t5_dout", 32'(dout), 32'h01);
    check("t5_valid", 32'(dout_valid), 32'd1);
    check("t5_no_ovf", 32'(overflow_err), 32'd0);

    // strobe with only one free slot sets overflow before the soft clear
    write_grp(8'hC1, 8'hC2);
    check("t5_ovf", 32'(overflow_err), 32'd1);
    pop(8'h02, "t5_pop2");
    pop(8'h03, "t5_pop3");
    check("t6_pre_count", 32'(count), 32'd5);

    // 6. inner_rst mid-stream with read_en
    inner_rst = 1'b1;
    read_en = 1'b1;
    tick();
    inner_rst = 1'b0;
    read_en = 1'b0;
    check("t6_count", 32'(count), 32'd0);
    check("t6_valid", 32'(dout_valid), 32'd0);
    check("t6_flags", 32'({overflow_err, underflow_err}), 32'd0);
    check("t6_ready", 32'(ready), 32'd1);
    check("t6_dout", 32'(dout), 32'd0);
    tick();
    check("t6_valid_next", 32'(dout_valid), 32'd0);
    check("t6_ready_next", 32'(ready), 32'd1);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
